// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a falling-edge RAM.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface mem_arbiter_if #(
   parameter int DSIZE = 32,
   parameter int ASIZE = 20
);
   logic             m0_req;
   logic             m0_rnw;
   logic [ASIZE-1:0] m0_addr;
   logic [DSIZE-1:0] m0_wdata;
   logic             m0_ack;
   logic             m1_req;
   logic             m1_rnw;
   logic [ASIZE-1:0] m1_addr;
   logic [DSIZE-1:0] m1_wdata;
   logic             m1_ack;
   logic [DSIZE-1:0] rdata;
   logic [ASIZE-1:0] ram_address;
   logic [DSIZE-1:0] ram_din;
   logic             ram_rnw;
   logic             ram_cs_b;
   logic [DSIZE-1:0] ram_dout;

   modport slave (
      input  m0_req, m0_rnw, m0_addr, m0_wdata,
      input  m1_req, m1_rnw, m1_addr, m1_wdata,
      input  ram_dout,
      output m0_ack, m1_ack, rdata,
      output ram_address, ram_din, ram_rnw, ram_cs_b
   );

   modport master (
      output m0_req, m0_rnw, m0_addr, m0_wdata,
      output m1_req, m1_rnw, m1_addr, m1_wdata,
      output ram_dout,
      input  m0_ack, m1_ack, rdata,
      input  ram_address, ram_din, ram_rnw, ram_cs_b
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported RAM clocked on the falling edge.
// Each access is IDLE/DONE -> ACCESS -> DONE; DONE may hand straight over to the other port.
module mem_arbiter #(
   parameter int DSIZE = 32,
   parameter int ASIZE = 20
) (
   input  logic          clk,
   input  logic          reset_b,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             gnt;
   logic             gnt_nxt;
   logic             grant;
   logic             last;
   logic [ASIZE-1:0] ram_address;
   logic [DSIZE-1:0] ram_din;
   logic             ram_rnw;
   logic             ram_cs_b;
   logic [DSIZE-1:0] rdata;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) state <= IDLE;
      else          state <= state_nxt;
   end

   // DONE only looks at the other port so a req still high from the port just served is ignored
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      gnt_nxt   = gnt;
      case (state)
         IDLE: begin
            if (bus.m0_req && bus.m1_req) begin
               grant   = 1'b1;
               gnt_nxt = ~last;
            end else if (bus.m0_req) begin
               grant   = 1'b1;
               gnt_nxt = 1'b0;
            end else if (bus.m1_req) begin
               grant   = 1'b1;
               gnt_nxt = 1'b1;
            end
         end
         ACCESS: state_nxt = DONE;
         DONE: begin
            state_nxt = IDLE;
            if (gnt ? bus.m0_req : bus.m1_req) begin
               grant   = 1'b1;
               gnt_nxt = ~gnt;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (grant) state_nxt = ACCESS;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         gnt         <= 1'b0;
         last        <= 1'b1;
         ram_cs_b    <= 1'b1;
         ram_rnw     <= 1'b1;
         ram_address <= '0;
         ram_din     <= '0;
         rdata       <= '0;
      end else if (grant) begin
         gnt         <= gnt_nxt;
         ram_cs_b    <= 1'b0;
         ram_address <= gnt_nxt ? bus.m1_addr  : bus.m0_addr;
         ram_din     <= gnt_nxt ? bus.m1_wdata : bus.m0_wdata;
         ram_rnw     <= gnt_nxt ? bus.m1_rnw   : bus.m0_rnw;
      end else if (state == ACCESS) begin
         // RAM has already presented its word on the falling edge inside ACCESS
         ram_cs_b <= 1'b1;
         last     <= gnt;
         if (ram_rnw) rdata <= bus.ram_dout;
      end
   end

   assign bus.m0_ack      = (state == DONE) && !gnt;
   assign bus.m1_ack      = (state == DONE) &&  gnt;
   assign bus.rdata       = rdata;
   assign bus.ram_address = ram_address;
   assign bus.ram_din     = ram_din;
   assign bus.ram_rnw     = ram_rnw;
   assign bus.ram_cs_b    = ram_cs_b;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a falling-edge RAM model, per-port drivers and
// a negedge monitor that checks every RAM access and every ack against the expected queue.
module tb_mem_arbiter;

   typedef struct {
      bit          port;
      bit          rnw;
      logic [19:0] addr;
      logic [31:0] data;
   } txn_t;

   logic clk;
   logic reset_b;
   int   total;
   int   bad;
   int   cyc;
   int   ack_cnt [2];
   int   ack_cyc [2];
   bit   tb_last;
   txn_t sb [$];
   txn_t txq0 [$];
   txn_t txq1 [$];
   txn_t mon_e;
   logic [31:0] ram_mem [256];
   logic [31:0] ref_mem [256];

   mem_arbiter_if #(.DSIZE(32), .ASIZE(20)) bus ();

   mem_arbiter #(.DSIZE(32), .ASIZE(20)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: select sampled on the falling edge
   always @(negedge clk) begin
      if (!bus.ram_cs_b) begin
         if (bus.ram_rnw) bus.ram_dout <= ram_mem[bus.ram_address[7:0]];
         else             ram_mem[bus.ram_address[7:0]] <= bus.ram_din;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic expect_txn(input bit p, input bit rnw, input logic [19:0] a,
                             input logic [31:0] d, input bit to_port);
      txn_t e;
      e.port = p;
      e.rnw  = rnw;
      e.addr = a;
      if (rnw) e.data = ref_mem[a[7:0]];
      else begin
         ref_mem[a[7:0]] = d;
         e.data = d;
      end
      sb.push_back(e);
      tb_last = p;
      if (to_port) begin
         if (p) txq1.push_back(e);
         else   txq0.push_back(e);
      end
   endtask

   task automatic drive_port(input bit p, input logic req, input logic rnw,
                             input logic [19:0] a, input logic [31:0] d);
      if (!p) begin
         bus.m0_req = req; bus.m0_rnw = rnw; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = req; bus.m1_rnw = rnw; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   function automatic logic ack_of(input bit p);
      return p ? bus.m1_ack : bus.m0_ack;
   endfunction

   // Holds req across back-to-back transactions, moving to the next one on each ack
   task automatic run_port(input bit p);
      txn_t t;
      int   w;
      @(posedge clk); #1;
      while ((p ? txq1.size() : txq0.size()) != 0) begin
         if (p) t = txq1.pop_front();
         else   t = txq0.pop_front();
         drive_port(p, 1'b1, t.rnw, t.addr, t.data);
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!ack_of(p) && w < 30);
         check_val(p ? "ack_wait_m1" : "ack_wait_m0", ack_of(p), 1'b1);
         ack_cyc[p] = cyc;
      end
      drive_port(p, 1'b0, 1'b1, '0, '0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!bus.ram_cs_b) begin
            check_val("access_pending", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               check_val("ram_address", bus.ram_address, sb[0].addr);
               check_val("ram_rnw", bus.ram_rnw, sb[0].rnw);
               if (!sb[0].rnw) check_val("ram_din", bus.ram_din, sb[0].data);
            end
         end
         if (bus.m0_ack || bus.m1_ack) begin
            check_val("dual_ack", bus.m0_ack & bus.m1_ack, 1'b0);
            check_val("ack_pending", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check_val("ack_port", bus.m1_ack, mon_e.port);
               if (mon_e.rnw) check_val("rdata", bus.rdata, mon_e.data);
               ack_cnt[bus.m1_ack ? 1 : 0]++;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int c0;
      bit first;
      total = 0; bad = 0; cyc = 0;
      ack_cnt[0] = 0; ack_cnt[1] = 0;
      tb_last = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      ram_mem[8'h10] = 32'hDEADBEEF;
      ref_mem[8'h10] = 32'hDEADBEEF;
      bus.ram_dout = '0;
      drive_port(1'b0, 1'b0, 1'b1, '0, '0);
      drive_port(1'b1, 1'b0, 1'b1, '0, '0);

      // asynchronous reset before any clock edge
      reset_b = 1'b1;
      #2 reset_b = 1'b0;
      #1;
      check_val("rst_m0_ack", bus.m0_ack, 1'b0);
      check_val("rst_m1_ack", bus.m1_ack, 1'b0);
      check_val("rst_cs_b", bus.ram_cs_b, 1'b1);
      check_val("rst_rnw", bus.ram_rnw, 1'b1);
      check_val("rst_address", bus.ram_address, 20'h0);
      check_val("rst_din", bus.ram_din, 32'h0);
      check_val("rst_rdata", bus.rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_b = 1'b1;

      // first tie after reset goes to port 0, port 1 follows from DONE
      expect_txn(1'b0, 1'b0, 20'h00020, 32'h0BADF00D, 1'b1);
      expect_txn(1'b1, 1'b1, 20'h00010, 32'h0, 1'b1);
      fork
         run_port(1'b0);
         run_port(1'b1);
      join
      check_val("tie_gap", ack_cyc[1] - ack_cyc[0], 2);

      // single read with exact latency; address changed after the grant edge
      @(posedge clk); #1;
      expect_txn(1'b0, 1'b1, 20'h00010, 32'h0, 1'b0);
      drive_port(1'b0, 1'b1, 1'b1, 20'h00010, 32'h0);
      @(posedge clk); #1;
      drive_port(1'b0, 1'b1, 1'b0, 20'h003FF, 32'hFFFFFFFF);
      check_val("read_cs_n1", bus.ram_cs_b, 1'b0);
      check_val("read_noack_n1", bus.m0_ack, 1'b0);
      @(posedge clk); #1;
      check_val("read_ack_n2", bus.m0_ack, 1'b1);
      check_val("read_rdata_n2", bus.rdata, 32'hDEADBEEF);
      drive_port(1'b0, 1'b0, 1'b1, '0, '0);
      @(posedge clk); #1;
      check_val("read_ack_pulse", bus.m0_ack, 1'b0);
      check_val("read_cs_idle", bus.ram_cs_b, 1'b1);

      // write from port 1 then read back from port 0
      expect_txn(1'b1, 1'b0, 20'h00004, 32'h12345678, 1'b1);
      run_port(1'b1);
      expect_txn(1'b0, 1'b1, 20'h00004, 32'h0, 1'b1);
      run_port(1'b0);
      check_val("wr_rd_data", bus.rdata, 32'h12345678);
      check_val("wr_rd_rnw_hold", bus.ram_rnw, 1'b1);

      // port 0 pulses req only while port 1 is in ACCESS: never served
      c0 = ack_cnt[0];
      @(posedge clk); #1;
      expect_txn(1'b1, 1'b0, 20'h00030, 32'h55AA55AA, 1'b0);
      drive_port(1'b1, 1'b1, 1'b0, 20'h00030, 32'h55AA55AA);
      @(posedge clk); #1;
      drive_port(1'b0, 1'b1, 1'b0, 20'h00031, 32'h11111111);
      @(negedge clk);
      drive_port(1'b0, 1'b0, 1'b1, '0, '0);
      @(negedge clk);
      check_val("pulse_m1_ack", bus.m1_ack, 1'b1);
      drive_port(1'b1, 1'b0, 1'b1, '0, '0);
      repeat (4) @(negedge clk);
      check_val("pulse_no_m0_ack", ack_cnt[0] - c0, 0);
      check_val("pulse_cs_idle", bus.ram_cs_b, 1'b1);

      // sustained contention: grants alternate starting with the port not served last
      first = !tb_last;
      for (int k = 0; k < 8; k++) begin
         bit          p;
         int          i;
         logic [19:0] a;
         p = first ^ k[0];
         i = k >> 1;
         a = 20'h40 + (p ? 20'h10 : 20'h0) + 20'(i & ~1);
         expect_txn(p, i[0], a, 32'hA0000000 | (32'(p) << 8) | 32'(i), 1'b1);
      end
      c0 = ack_cnt[0] + ack_cnt[1];
      fork
         run_port(1'b0);
         run_port(1'b1);
      join
      check_val("contention_acks", ack_cnt[0] + ack_cnt[1] - c0, 8);
      check_val("contention_drained", sb.size(), 0);

      // reset during ACCESS aborts the transfer
      @(posedge clk); #1;
      expect_txn(1'b1, 1'b1, 20'h00010, 32'h0, 1'b0);
      drive_port(1'b1, 1'b1, 1'b1, 20'h00010, 32'h0);
      @(posedge clk); #1;
      check_val("abort_cs_low", bus.ram_cs_b, 1'b0);
      #1 reset_b = 1'b0;
      #1;
      check_val("abort_cs_async", bus.ram_cs_b, 1'b1);
      check_val("abort_m1_ack", bus.m1_ack, 1'b0);
      check_val("abort_address", bus.ram_address, 20'h0);
      sb.delete();
      drive_port(1'b1, 1'b0, 1'b1, '0, '0);
      c0 = ack_cnt[0] + ack_cnt[1];
      repeat (2) @(posedge clk);
      #1 reset_b = 1'b1;
      repeat (3) @(negedge clk);
      check_val("abort_no_ack", ack_cnt[0] + ack_cnt[1] - c0, 0);

      tb_last = 1'b1;
      expect_txn(1'b0, 1'b1, 20'h00004, 32'h0, 1'b1);
      expect_txn(1'b1, 1'b1, 20'h00010, 32'h0, 1'b1);
      fork
         run_port(1'b0);
         run_port(1'b1);
      join
      check_val("post_rst_tie_gap", ack_cyc[1] - ack_cyc[0], 2);
      check_val("final_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
